// File: rtl/i2s_pkg.sv
// i2s_pkg
//   Shared definitions for the I2S transmit path: FSM state encoding,
//   default geometry (sample width, slot width, BCLK divider) and the
//   width of the optional underrun counter with its saturating increment.
//   No ports; imported by i2s_bclk_gen and i2s_tx.
package i2s_pkg;

  // Default frame geometry
  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned SLOT_W_DEF     = 32;
  localparam int unsigned BCLK_DIV_DEF   = 2;

  // Width of the underrun event counter
  localparam int unsigned UNDERRUN_CNT_W = 8;

  // Transmit FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(
    input logic [UNDERRUN_CNT_W-1:0] value
  );
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen
//   Bit-clock generator. Divides the system clock so that bclk toggles
//   every BCLK_DIV cycles while run is high, and reports each toggle as a
//   single-cycle rise or fall strobe in the cycle before the new level
//   appears on bclk.
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   run_i        divider runs while high; held at zero with bclk low otherwise
//   force_low_i  park the divider at zero and bclk low on the next edge
//   bclk_o       registered bit clock
//   rise_tick_o  this edge takes bclk 0->1
//   fall_tick_o  this edge takes bclk 1->0
module i2s_bclk_gen
  import i2s_pkg::*;
#(
  parameter int unsigned BCLK_DIV = BCLK_DIV_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic force_low_i,
  output logic bclk_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic             terminal;

  // The strobes depend only on registered state and run, never on
  // force_low, so the top can use a fall tick to decide to force low.
  assign terminal    = run_i && (div_cnt_q == DIV_LAST);
  assign rise_tick_o = terminal && !bclk_q;
  assign fall_tick_o = terminal && bclk_q;
  assign bclk_o      = bclk_q;

  // Next-state for the divider and bit clock
  always_comb begin
    div_cnt_d = div_cnt_q;
    bclk_d    = bclk_q;
    if (!run_i || force_low_i) begin
      div_cnt_d = '0;
      bclk_d    = 1'b0;
    end else if (terminal) begin
      div_cnt_d = '0;
      bclk_d    = !bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  // Divider and bclk registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx
//   I2S transmitter for the anti-noise output. Accepts stereo sample pairs
//   over valid/ready into a one-pair shadow buffer and serialises them
//   MSB-first in standard I2S framing (LRCLK leads data by one BCLK).
//   Frames that start with an empty shadow carry zeros and raise underrun.
// Ports:
//   clk_i           system clock
//   rst_i           synchronous active-high reset
//   en_i            run enable; clearing it lets the current frame finish
//   in_valid_i      sample pair valid
//   in_ready_o      shadow buffer empty
//   in_left_i       left sample, two's complement
//   in_right_i      right sample, two's complement
//   bclk_o          bit clock to the DAC
//   lrclk_o         word select, 0 = left
//   sdata_o         serial data, changes on falling bclk
//   underrun_o      one-cycle pulse when a frame starts with no pair loaded
//   underrun_cnt_o  saturating underrun count (only with
//                   I2S_TX_UNDERRUN_CNT_EN defined)
// Optional feature macro: I2S_TX_UNDERRUN_CNT_EN
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned SLOT_W   = SLOT_W_DEF,
  parameter int unsigned BCLK_DIV = BCLK_DIV_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_left_i,
  input  logic [DATA_W-1:0] in_right_i,
  output logic              bclk_o,
  output logic              lrclk_o,
  output logic              sdata_o,
  output logic              underrun_o
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt_o
`endif
);

  localparam int unsigned B_W = $clog2(2 * SLOT_W);
  localparam logic [B_W-1:0] B_LAST    = B_W'(2 * SLOT_W - 1);
  localparam logic [B_W-1:0] LR_FIRST  = B_W'(SLOT_W - 1);
  localparam logic [B_W-1:0] LR_LAST   = B_W'(2 * SLOT_W - 2);
  localparam logic [B_W-1:0] SLOT_SIZE = B_W'(SLOT_W);
  localparam logic [B_W-1:0] DATA_SIZE = B_W'(DATA_W);

  state_t            state_q, state_d;
  logic              active_q, active_d;
  logic [B_W-1:0]    b_q, b_d;
  logic              lrclk_q, lrclk_d;
  logic              sdata_q, sdata_d;
  logic              underrun_q, underrun_d;
  logic              in_ready_q, in_ready_d;
  logic              shadow_full_q, shadow_full_d;
  logic [DATA_W-1:0] shadow_left_q, shadow_left_d;
  logic [DATA_W-1:0] shadow_right_q, shadow_right_d;
  logic [DATA_W-1:0] shift_left_q, shift_left_d;
  logic [DATA_W-1:0] shift_right_q, shift_right_d;

  logic              run;
  logic              fall_tick;
  logic              rise_tick_unused;
  logic              frame_tick;
  logic              stop_now;
  logic              frame_start;
  logic              accept;

  logic [DATA_W-1:0] load_left, load_right, src_word;
  logic              right_slot;
  logic [B_W-1:0]    s_d;

  assign run = (state_q != ST_IDLE);

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .run_i       (run),
    .force_low_i (stop_now),
    .bclk_o      (bclk_o),
    .rise_tick_o (rise_tick_unused),
    .fall_tick_o (fall_tick)
  );

  // A frame boundary is either the first fall after leaving IDLE or the
  // fall that wraps b. While draining with en still low, that boundary
  // stops the transmitter instead of opening a new frame.
  assign frame_tick  = fall_tick && (!active_q || (b_q == B_LAST));
  assign stop_now    = frame_tick && (state_q == ST_DRAIN) && !en_i;
  assign frame_start = frame_tick && !stop_now;
  assign accept      = in_valid_i && in_ready_q;

  // Run-control FSM. DRAIN returns to RUN untouched if en comes back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en_i) state_d = ST_RUN;
      ST_RUN:   if (!en_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (stop_now)  state_d = ST_IDLE;
        else if (en_i) state_d = ST_RUN;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Shadow buffer. A frame start empties it before a same-cycle handshake
  // refills it, so a pair arriving exactly at frame start waits a frame.
  always_comb begin
    shadow_full_d  = shadow_full_q;
    shadow_left_d  = shadow_left_q;
    shadow_right_d = shadow_right_q;
    if (frame_start && shadow_full_q) begin
      shadow_full_d = 1'b0;
    end
    if (accept) begin
      shadow_left_d  = in_left_i;
      shadow_right_d = in_right_i;
      shadow_full_d  = 1'b1;
    end
    in_ready_d = !shadow_full_d;
    underrun_d = frame_start && !shadow_full_q;
  end

  // Serialiser. On each fall tick b advances and the bit for the new b is
  // registered, so the left MSB leaves in the same edge that opens b=0.
  // Each slot word shifts left once per emitted bit.
  always_comb begin
    b_d           = b_q;
    active_d      = active_q;
    lrclk_d       = lrclk_q;
    sdata_d       = sdata_q;
    shift_left_d  = shift_left_q;
    shift_right_d = shift_right_q;
    load_left     = shadow_full_q ? shadow_left_q  : '0;
    load_right    = shadow_full_q ? shadow_right_q : '0;
    right_slot    = 1'b0;
    s_d           = '0;
    src_word      = '0;

    if (stop_now) begin
      b_d           = '0;
      active_d      = 1'b0;
      lrclk_d       = 1'b0;
      sdata_d       = 1'b0;
      shift_left_d  = '0;
      shift_right_d = '0;
    end else if (fall_tick) begin
      active_d   = 1'b1;
      b_d        = frame_start ? '0 : b_q + 1'b1;
      right_slot = (b_d >= SLOT_SIZE);
      s_d        = right_slot ? b_d - SLOT_SIZE : b_d;
      lrclk_d    = (b_d >= LR_FIRST) && (b_d <= LR_LAST);

      if (frame_start) begin
        shift_right_d = load_right;
      end

      if (right_slot) begin
        src_word = shift_right_q;
      end else begin
        src_word = frame_start ? load_left : shift_left_q;
      end

      if (s_d < DATA_SIZE) begin
        sdata_d = src_word[DATA_W-1];
        if (right_slot) shift_right_d = src_word << 1;
        else            shift_left_d  = src_word << 1;
      end else begin
        sdata_d = 1'b0;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      active_q       <= 1'b0;
      b_q            <= '0;
      lrclk_q        <= 1'b0;
      sdata_q        <= 1'b0;
      underrun_q     <= 1'b0;
      in_ready_q     <= 1'b1;
      shadow_full_q  <= 1'b0;
      shadow_left_q  <= '0;
      shadow_right_q <= '0;
      shift_left_q   <= '0;
      shift_right_q  <= '0;
    end else begin
      state_q        <= state_d;
      active_q       <= active_d;
      b_q            <= b_d;
      lrclk_q        <= lrclk_d;
      sdata_q        <= sdata_d;
      underrun_q     <= underrun_d;
      in_ready_q     <= in_ready_d;
      shadow_full_q  <= shadow_full_d;
      shadow_left_q  <= shadow_left_d;
      shadow_right_q <= shadow_right_d;
      shift_left_q   <= shift_left_d;
      shift_right_q  <= shift_right_d;
    end
  end

  assign lrclk_o    = lrclk_q;
  assign sdata_o    = sdata_q;
  assign underrun_o = underrun_q;
  assign in_ready_o = in_ready_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [UNDERRUN_CNT_W-1:0] underrun_cnt_q;

  // Count underrun pulses, sticking at the maximum; only reset clears it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      underrun_cnt_q <= '0;
    end else if (underrun_q) begin
      underrun_cnt_q <= sat_inc(underrun_cnt_q);
    end
  end

  assign underrun_cnt_o = underrun_cnt_q;
`endif

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Serial audio transmitter for the anti-noise output path. It takes stereo sample pairs from the ANC filter over a valid/ready handshake and drives an I2S DAC.
- Generates BCLK and LRCLK from the system clock and serialises the samples MSB-first, in standard I2S framing (LRCLK leads data by one BCLK).
- It is the transmit counterpart of the I2S capture path on the microphone side.

Parameters:
- DATA_W, 16: sample width per channel in bits.
- SLOT_W, 32: BCLK periods per channel slot. Must be >= DATA_W.
- BCLK_DIV, 2: BCLK half-period in clk cycles. Must be >= 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset.
- en  in  1  run enable; sampled every cycle.
- in_valid  in  1  sample pair valid.
- in_ready  out  1  shadow buffer empty, so a pair can be accepted.
- in_left  in  DATA_W  left sample, two's complement.
- in_right  in  DATA_W  right sample, two's complement.
- bclk  out  1  bit clock to DAC.
- lrclk  out  1  word select; 0 = left.
- sdata  out  1  serial data.
- underrun  out  1  one-cycle pulse when a frame starts with no sample pair loaded.

Behaviour:
- Reset:
  - One clock; rst is synchronous and active-high.
  - All outputs are registered. Reset values: bclk=0, lrclk=0, sdata=0, in_ready=1, underrun=0.
  - Reset also clears: div counter, bit counter b, shadow_full, and the shift registers. FSM goes to IDLE.
  - Reset mid-frame aborts the frame immediately and discards the shadow contents.
- Divider:
  - While in RUN or DRAIN, div_cnt counts 0..BCLK_DIV-1.
  - At terminal count, bclk toggles.
  - A rise tick is a 0->1 toggle; a fall tick is a 1->0 toggle.
- Frame:
  - b runs 0..2*SLOT_W-1 and advances on each fall tick, wrapping to 0.
  - All sdata and lrclk updates are registered on fall ticks only. The DAC samples on rising BCLK.
  - Slot position s = b mod SLOT_W.
  - sdata = bit (DATA_W-1-s) of the current slot word when s < DATA_W; otherwise 0.
  - Left slot is b in 0..SLOT_W-1; right slot is the remainder.
  - lrclk = 1 for b in SLOT_W-1..2*SLOT_W-2; otherwise 0.
- Buffering:
  - One shadow pair register.
  - in_ready = !shadow_full. A transfer happens on in_valid && in_ready; it captures the pair and sets shadow_full.
  - On the fall tick that starts b=0 with shadow_full=1, the shadow moves to the shift pair and shadow_full clears. in_ready rises the next cycle.
  - On the fall tick that starts b=0 with shadow_full=0, the shift pair is loaded with zeros and underrun pulses for that cycle.
  - If a handshake coincides with that frame-start tick, the new pair goes to the shadow, the frame is still zeros, and underrun still pulses.
  - Latency: the MSB of a loaded left sample is on sdata in the same registered cycle as the b=0 fall tick.
- FSM:
  - IDLE: bclk=0, lrclk=0, sdata=0, counters held at 0. Go to RUN when en=1.
    - The first rise tick comes BCLK_DIV cycles after entry to RUN.
    - The first fall tick starts b=0.
  - RUN: go to DRAIN when en=0.
  - DRAIN: continue the current frame. On the fall tick where b would wrap to 0, go to IDLE instead of starting a frame.
    - In that cycle: bclk=0, sdata=0, lrclk=0. No underrun pulse.
    - If en returns to 1 during DRAIN, go back to RUN with no disruption.
  - The shadow keeps accepting data in all states. A pair held at stop is sent in the first frame after restart.

Optional Feature:
- Macro I2S_TX_UNDERRUN_CNT_EN.
- When defined:
  - Adds output underrun_cnt, 8 bits.
  - Increments on each underrun pulse and saturates at 255.
  - Cleared by rst only.
- When undefined: the port and counter do not exist. The underrun pulse is unchanged.

Decomposition:
- Package i2s_pkg holds:
  - FSM state encoding: IDLE, RUN, DRAIN.
  - Default DATA_W, SLOT_W and BCLK_DIV constants.
  - The underrun counter width of 8.
- Sub-module i2s_bclk_gen is the natural split:
  - Contains the divider and the bclk register.
  - Emits rise_tick and fall_tick strobes.
  - Takes a run input and a force-low input.

Test Plan (DATA_W=16, SLOT_W=32, BCLK_DIV=2):
- Reset then en=1, with one pair left=16'hA5F0, right=16'h0F0F loaded before the first fall tick:
  - bclk period is 4 clk cycles.
  - Left slot sdata is 1010_0101_1111_0000 followed by 16 zeros.
  - lrclk rises at b=31 and falls at b=63.
- No data after the first frame: the second frame is all zeros, underrun pulses exactly one cycle at b=0, and in_ready=1 throughout.
- Hold in_valid=1 continuously with an incrementing pair (left=n, right=~n):
  - in_ready drops after each accept.
  - Exactly one accept per frame.
  - Frames carry n=0,1,2,... in order with no drops.
- Handshake on the exact frame-start cycle with shadow empty: underrun=1, that frame is zeros, and the pair appears in the next frame.
- Deassert en at b=10: the frame completes to b=63, the FSM goes to IDLE, bclk is held 0, and no underrun pulses.
- Assert rst at b=40: next cycle all outputs are at reset values, in_ready=1, and the shadow is discarded.
- With I2S_TX_UNDERRUN_CNT_EN defined:
  - 300 consecutive underrun frames leave underrun_cnt=255.
  - rst clears it to 0.
